mc_chroma_ip_ctrl: RTL

//  Sequencer for the single-pixel chroma interpolation filter (mc_chroma_ip_1p). Per chroma PU it walks
//  4-row bands, column by column, issuing 4-tap reference-window reads (7 rows per column if fracy!=0,

---
 rtl/mc_chroma_pkg.sv | 11 +
 rtl/mc_chroma_wr_agu.sv | 47 ++++
 rtl/mc_chroma_ip_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/mc_chroma_pkg.sv
// mc_chroma_pkg: shared FSM states and geometry constants for the chroma interpolation sequencer.
package mc_chroma_pkg;
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;
   localparam int CHROMA_TAPS  = 4;
   localparam int PRELOAD_ROWS = 3;
   localparam int BAND_ROWS    = 4;
   // Rows read per column: a vertical fraction needs the extra tap rows around the band.
   function automatic logic [2:0] rows_per_col(input logic [2:0] fy);
      return fy != 3'd0 ? 3'(CHROMA_TAPS + PRELOAD_ROWS) : 3'(CHROMA_TAPS);
   endfunction
endpackage

// File: rtl/mc_chroma_wr_agu.sv
// mc_chroma_wr_agu: prediction-buffer write address walker (row in band, column, band) plus write count.
module mc_chroma_wr_agu
   import mc_chroma_pkg::*;
#(
   parameter int BLK_W = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             en,
   input  logic [BLK_W-1:0] w,
   input  logic [BLK_W-1:0] h,
   output logic [BLK_W-1:0] x,
   output logic [BLK_W-1:0] y,
   output logic             last
);
   logic [1:0]         yb;
   logic [BLK_W-1:0]   col;
   logic [BLK_W-3:0]   band;
   logic [2*BLK_W-1:0] cnt, total;
   logic               col_last, yb_last;
   assign total    = {{BLK_W{1'b0}}, w} * {{BLK_W{1'b0}}, h};
   assign col_last = col == w - 1'b1;
   assign yb_last  = yb == 2'(BAND_ROWS - 1);
   // High on the write that brings the count to w*h.
   assign last     = en && cnt == total - 1'b1;
   assign x        = col;
   assign y        = {band, yb};
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         yb   <= '0;
         col  <= '0;
         band <= '0;
         cnt  <= '0;
      end else if (clr) begin
         yb   <= '0;
         col  <= '0;
         band <= '0;
         cnt  <= '0;
      end else if (en) begin
         yb  <= yb + 2'd1;
         cnt <= cnt + 1'b1;
         if (yb_last) col <= col_last ? '0 : col + 1'b1;
         if (yb_last && col_last) band <= band + 1'b1;
      end
   end
endmodule

// File: rtl/mc_chroma_ip_ctrl.sv
// mc_chroma_ip_ctrl: walks 4-row bands column by column issuing tap-window reads to the chroma filter
// and maps filter outputs to prediction-buffer write coordinates.
module mc_chroma_ip_ctrl
   import mc_chroma_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int BLK_W       = 6,
   parameter int REF_W       = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   input  logic [BLK_W-1:0] blk_w_i,
   input  logic [BLK_W-1:0] blk_h_i,
   input  logic [2:0]       fracx_i,
   input  logic [2:0]       fracy_i,
   input  logic             hold_i,
   output logic             ref_rd_en_o,
   output logic [REF_W-1:0] ref_rd_x_o,
   output logic [REF_W-1:0] ref_rd_y_o,
   output logic             blk_start_o,
   output logic [2:0]       fracx_o,
   output logic [2:0]       fracy_o,
   output logic             ref_valid_o,
   input  logic             fracuv_valid_i,
   output logic             pred_wr_en_o,
   output logic [BLK_W-1:0] pred_wr_x_o,
   output logic [BLK_W-1:0] pred_wr_y_o,
   output logic             busy_o,
   output logic             done_o
);
   if (PIXEL_WIDTH <= 0) begin : g_no_pixel_path
   end
   state_t           state, state_nx;
   logic [BLK_W-1:0] w, h, col;
   logic [BLK_W-3:0] band;
   logic [2:0]       row, rows;
   logic             rd_en, row_last, col_last, band_last, last_rd, wr_en, wr_last;
   assign rows      = rows_per_col(fracy_o);
   assign rd_en     = state == S_RUN && !hold_i;
   assign row_last  = row == rows - 3'd1;
   assign col_last  = col == w - 1'b1;
   assign band_last = {2'b00, band} == (h >> 2) - 1'b1;
   assign last_rd   = rd_en && row_last && col_last && band_last;
   assign wr_en     = fracuv_valid_i && (state == S_RUN || state == S_DRAIN);
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= S_IDLE;
         w           <= '0;
         h           <= '0;
         fracx_o     <= '0;
         fracy_o     <= '0;
         ref_valid_o <= 1'b0;
         row         <= '0;
         col         <= '0;
         band        <= '0;
      end else begin
         state       <= state_nx;
         ref_valid_o <= rd_en;
         if (state == S_IDLE && start_i) begin
            w       <= blk_w_i;
            h       <= blk_h_i;
            fracx_o <= fracx_i;
            fracy_o <= fracy_i;
         end
         if (state == S_INIT) begin
            row  <= '0;
            col  <= '0;
            band <= '0;
         end else if (rd_en) begin
            row <= row_last ? '0 : row + 3'd1;
            if (row_last) col <= col_last ? '0 : col + 1'b1;
            if (row_last && col_last) band <= band + 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = start_i ? S_INIT : S_IDLE;
         S_INIT:  state_nx = S_RUN;
         S_RUN:   state_nx = last_rd ? S_DRAIN : S_RUN;
         S_DRAIN: state_nx = wr_last ? S_DONE : S_DRAIN;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end
   // Window starts one column left and, with a vertical fraction, one row above the band.
   assign ref_rd_en_o  = rd_en;
   assign ref_rd_x_o   = rd_en ? REF_W'(col) - REF_W'(1) : '0;
   assign ref_rd_y_o   = rd_en ? REF_W'({band, 2'b00}) + REF_W'(row) - REF_W'(fracy_o != 3'd0) : '0;
   assign blk_start_o  = state == S_INIT;
   assign busy_o       = state != S_IDLE;
   assign done_o       = state == S_DONE;
   assign pred_wr_en_o = wr_en;
   mc_chroma_wr_agu #(.BLK_W(BLK_W)) u_wr_agu (
      .clk  (clk),
      .rstn (rstn),
      .clr  (state == S_INIT),
      .en   (wr_en),
      .w    (w),
      .h    (h),
      .x    (pred_wr_x_o),
      .y    (pred_wr_y_o),
      .last (wr_last)
   );
endmodule
